// File: rtl/cpu_pkg.sv
// Shared CPU types and constants for the writeback register file and its
// pending-write scoreboard.
package cpu_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int PEND_W     = 2;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xword_t;
    typedef logic [PEND_W-1:0]     pend_cnt_t;

    localparam reg_addr_t REG_ZERO   = 5'd0;
    localparam xword_t    XWORD_ZERO = 32'h0000_0000;
    localparam pend_cnt_t PEND_ZERO  = 2'd0;
    localparam pend_cnt_t PEND_ONE   = 2'd1;
    localparam pend_cnt_t PEND_MAX   = {PEND_W{1'b1}};

    // Saturating step counts: an overflowing issue or idle retire leaves the count alone
    function automatic pend_cnt_t pend_issue(input pend_cnt_t cnt);
        return (cnt == PEND_MAX) ? cnt : cnt + PEND_ONE;
    endfunction

    function automatic pend_cnt_t pend_retire(input pend_cnt_t cnt);
        return (cnt == PEND_ZERO) ? cnt : cnt - PEND_ONE;
    endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write counters with busy lookup for two source addresses.
// WB_REGFILE_BYPASS_EN: a producer retiring this cycle no longer counts as busy.
module regfile_scoreboard
    import cpu_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      issue_en,
    input  reg_addr_t issue_addr,
    input  logic      retire_en,
    input  reg_addr_t retire_addr,
    input  reg_addr_t rs1_addr,
    input  reg_addr_t rs2_addr,
    output logic      rs1_busy,
    output logic      rs2_busy
);
    pend_cnt_t             cnt_r     [NUM_REGS];
    pend_cnt_t             cnt_nxt_s [NUM_REGS];
    logic [NUM_REGS-1:1]   issue_hit_s;
    logic [NUM_REGS-1:1]   retire_hit_s;
    logic [NUM_REGS-1:1]   overflow_s;
    logic [NUM_REGS-1:1]   underflow_s;
    pend_cnt_t             rs1_cnt_s;
    pend_cnt_t             rs2_cnt_s;

    // Decode which counters see an issue or a retirement this cycle
    always_comb begin
        issue_hit_s  = {(NUM_REGS-1){1'b0}};
        retire_hit_s = {(NUM_REGS-1){1'b0}};
        for (int r = 1; r < NUM_REGS; r++) begin
            issue_hit_s[r]  = issue_en  && (issue_addr  == reg_addr_t'(r));
            retire_hit_s[r] = retire_en && (retire_addr == reg_addr_t'(r));
        end
    end

    // Next count per register; issue and retire together cancel out, x0 never counts
    always_comb begin
        overflow_s   = {(NUM_REGS-1){1'b0}};
        underflow_s  = {(NUM_REGS-1){1'b0}};
        cnt_nxt_s[0] = PEND_ZERO;
        for (int r = 1; r < NUM_REGS; r++) begin
            case ({issue_hit_s[r], retire_hit_s[r]})
                2'b10: begin
                    cnt_nxt_s[r]  = pend_issue(cnt_r[r]);
                    overflow_s[r] = (cnt_r[r] == PEND_MAX);
                end
                2'b01: begin
                    cnt_nxt_s[r]   = pend_retire(cnt_r[r]);
                    underflow_s[r] = (cnt_r[r] == PEND_ZERO);
                end
                default: cnt_nxt_s[r] = cnt_r[r];
            endcase
        end
    end

    // Counter state; reset drops every in-flight record at once
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 0; r < NUM_REGS; r++) cnt_r[r] <= PEND_ZERO;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) cnt_r[r] <= cnt_nxt_s[r];
        end
    end

    // Busy lookup for both read ports
    always_comb begin
`ifdef WB_REGFILE_BYPASS_EN
        if (retire_en && (retire_addr == rs1_addr)) begin
            rs1_cnt_s = pend_retire(cnt_r[rs1_addr]);
        end else begin
            rs1_cnt_s = cnt_r[rs1_addr];
        end
        if (retire_en && (retire_addr == rs2_addr)) begin
            rs2_cnt_s = pend_retire(cnt_r[rs2_addr]);
        end else begin
            rs2_cnt_s = cnt_r[rs2_addr];
        end
`else
        rs1_cnt_s = cnt_r[rs1_addr];
        rs2_cnt_s = cnt_r[rs2_addr];
`endif
        rs1_busy = (rs1_cnt_s != PEND_ZERO);
        rs2_busy = (rs2_cnt_s != PEND_ZERO);
    end

    regfile_scoreboard_chk u_chk (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .overflow    (|overflow_s),
        .underflow   (|underflow_s),
        .issue_addr  (issue_addr),
        .retire_addr (retire_addr)
    );
endmodule

// File: rtl/regfile_scoreboard_chk.sv
// Flags pending-write counter misuse: issuing past the in-flight limit, or
// retiring a register that has no producer in flight.
module regfile_scoreboard_chk
    import cpu_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      overflow,
    input  logic      underflow,
    input  reg_addr_t issue_addr,
    input  reg_addr_t retire_addr
);
    // Sample the misuse flags on every active edge outside reset
    always @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!overflow)
                else $warning("regfile_scoreboard: issue to x%0d with counter already saturated", issue_addr);
            assert (!underflow)
                else $warning("regfile_scoreboard: retire of x%0d with no write in flight", retire_addr);
        end
    end
endmodule

// File: rtl/wb_regfile.sv
// Writeback-end register file: two combinational read ports plus a pending-write
// scoreboard. WB_REGFILE_BYPASS_EN forwards the writeback value to same-cycle reads.
module wb_regfile
    import cpu_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  RegWrite_i,
    input  logic [REG_ADDR_W-1:0] RDaddr_i,
    input  logic [XLEN-1:0]       RDdata_i,
    input  logic [REG_ADDR_W-1:0] RS1addr_i,
    input  logic [REG_ADDR_W-1:0] RS2addr_i,
    output logic [XLEN-1:0]       RS1data_o,
    output logic [XLEN-1:0]       RS2data_o,
    input  logic                  IssueValid_i,
    input  logic                  IssueRegWrite_i,
    input  logic [REG_ADDR_W-1:0] IssueRDaddr_i,
    output logic                  RS1busy_o,
    output logic                  RS2busy_o
);
    xword_t regs_r [NUM_REGS];
    logic   wr_en_s;

    assign wr_en_s = RegWrite_i && (RDaddr_i != REG_ZERO);

    function automatic xword_t read_port(input reg_addr_t addr);
        xword_t data;
        if (addr == REG_ZERO) begin
            data = XWORD_ZERO;
`ifdef WB_REGFILE_BYPASS_EN
        end else if (wr_en_s && !rst_i && (RDaddr_i == addr)) begin
            data = RDdata_i;
`endif
        end else begin
            data = regs_r[addr];
        end
        return data;
    endfunction

    // Architectural register storage; x0 is never written
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) regs_r[i] <= XWORD_ZERO;
        end else if (wr_en_s) begin
            regs_r[RDaddr_i] <= RDdata_i;
        end
    end

    // Combinational read ports
    always_comb begin
        RS1data_o = read_port(RS1addr_i);
        RS2data_o = read_port(RS2addr_i);
    end

    regfile_scoreboard u_scoreboard (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .issue_en    (IssueValid_i && IssueRegWrite_i),
        .issue_addr  (IssueRDaddr_i),
        .retire_en   (RegWrite_i),
        .retire_addr (RDaddr_i),
        .rs1_addr    (RS1addr_i),
        .rs2_addr    (RS2addr_i),
        .rs1_busy    (RS1busy_o),
        .rs2_busy    (RS2busy_o)
    );
endmodule
